ddr_sdram_responder: RTL and testbench

- Synthesizable DDR SDRAM device-side responder: the memory end of the controller/memory command interface.
- Decodes controller commands (LOAD MODE, ACTIVE, READ, WRITE, PRECHARGE, REFRESH), tracks per-bank open rows, stores write bursts and returns read bursts after the programmed CAS latency.
- Runs on a single clock; both DDR edges are folded into one 2×DQ_W word per clock.
- Used as the target for controller-side stimulus in the DDR environment; flags protocol violations as single-cycle error pulses.

---
 rtl/ddr_sdram_responder.sv | 203 ++++++++++++++++++++
 tb/tb_ddr_sdram_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_sdram_responder.sv
// DDR SDRAM device-side responder: decodes controller commands, tracks the
// open row of each of the four banks, stores write bursts and returns read
// bursts after the programmed CAS latency. Both DDR edges are folded into a
// single 2*DQ_W word per clock: the low half is the first beat.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cs_n/ras_n/cas_n/we_n   command strobes (active low)
//   ba, addr                bank and row/column/mode address
//   dq_in, dm               write data word and byte masks (1 = keep byte)
//   dq_out, dq_oe           registered read data and its valid/drive enable
//   err_*                   one-cycle protocol violation pulses
//   refresh_cnt             accepted REFRESH count, saturating
//
// state    | meaning
// IDLE     | no burst in flight, READ/WRITE may be accepted
// WR_BURST | capturing write words, one per cycle
// RD_WAIT  | CAS latency countdown before the first read word
// RD_BURST | presenting read words on dq_out
module ddr_sdram_responder #(
   parameter int DQ_W   = 16,
   parameter int ADDR_W = 12,
   parameter int ROW_W  = 4,
   parameter int COL_W  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs_n,
   input  logic                  ras_n,
   input  logic                  cas_n,
   input  logic                  we_n,
   input  logic [1:0]            ba,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [2*DQ_W-1:0]     dq_in,
   input  logic [2*DQ_W/8-1:0]   dm,
   output logic [2*DQ_W-1:0]     dq_out,
   output logic                  dq_oe,
   output logic                  err_idle_bank,
   output logic                  err_act_open,
   output logic                  err_refresh,
   output logic                  err_collide,
   output logic [15:0]           refresh_cnt
);

   localparam int PC_W  = COL_W - 1;           // column of a two-beat word
   localparam int IDX_W = 2 + ROW_W + PC_W;
   localparam int DM_W  = 2*DQ_W/8;

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cmd;
   logic              is_lmr, is_act, is_rd, is_wr, is_pre, is_ref;
   logic              rw_cmd, busy, accept;
   logic [3:0]        bank_open;
   logic [ROW_W-1:0]  bank_row [4];
   logic [2:0]        nb_mode;                 // words per burst: 1, 2 or 4
   logic              cl3;
   logic [1:0]        bank_q;
   logic [ROW_W-1:0]  row_q;
   logic [PC_W-1:0]   col_q, col_next, wrap;
   logic [2:0]        nb_q, cnt_q;
   logic              mem_we, rd_fetch;
   logic [IDX_W-1:0]  idx;
   logic [2*DQ_W-1:0] mem [2**IDX_W];
   logic              unused_addr;

   // Only some address bits carry meaning; fold the rest into a sink.
   assign unused_addr = ^addr;

   assign cmd    = {ras_n, cas_n, we_n};
   assign is_lmr = !cs_n && cmd == 3'b000;
   assign is_act = !cs_n && cmd == 3'b011;
   assign is_rd  = !cs_n && cmd == 3'b101;
   assign is_wr  = !cs_n && cmd == 3'b100;
   assign is_pre = !cs_n && cmd == 3'b010;
   assign is_ref = !cs_n && cmd == 3'b001;

   assign rw_cmd = is_rd || is_wr;
   assign busy   = state_q != IDLE;
   assign accept = rw_cmd && bank_open[ba] && !busy;

   // Sequential wrap inside the burst-aligned block of words.
   assign wrap     = PC_W'(nb_q - 3'd1);
   assign col_next = (col_q & ~wrap) | ((col_q + PC_W'(1)) & wrap);
   assign idx      = {bank_q, row_q, col_q};

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = is_wr ? WR_BURST : RD_WAIT;
         WR_BURST: if (cnt_q == 3'd0) state_d = IDLE;
         RD_WAIT:  if (cnt_q == 3'd0) state_d = RD_BURST;
         RD_BURST: if (cnt_q == 3'd0) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_we   = 1'b0;
      rd_fetch = 1'b0;
      case (state_q)
         WR_BURST: mem_we   = 1'b1;
         RD_WAIT:  rd_fetch = cnt_q == 3'd0;
         RD_BURST: rd_fetch = cnt_q != 3'd0;
         default:  ;
      endcase
   end

   // Burst address/count latch; cnt_q is the wait countdown in RD_WAIT and
   // the remaining-words countdown in the burst states.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 3'd0;
      end else if (accept) begin
         bank_q <= ba;
         row_q  <= bank_row[ba];
         col_q  <= addr[COL_W-1:1];
         nb_q   <= nb_mode;
         cnt_q  <= is_wr ? nb_mode - 3'd1 : (cl3 ? 3'd1 : 3'd0);
      end else begin
         if (busy && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
         else if (state_q == RD_WAIT) cnt_q <= nb_q - 3'd1;
         if (mem_we || rd_fetch) col_q <= col_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bank_open <= 4'b0000;
      end else begin
         if (is_act && !bank_open[ba]) bank_open[ba] <= 1'b1;
         if (is_pre) begin
            if (addr[10]) bank_open <= 4'b0000;
            else          bank_open[ba] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && is_act && !bank_open[ba]) bank_row[ba] <= addr[ROW_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nb_mode <= 3'd2;
         cl3     <= 1'b0;
      end else if (is_lmr && ba == 2'd0) begin
         case (addr[2:0])
            3'd1:    nb_mode <= 3'd1;
            3'd2:    nb_mode <= 3'd2;
            3'd3:    nb_mode <= 3'd4;
            default: ;
         endcase
         case (addr[6:4])
            3'd2:    cl3 <= 1'b0;
            3'd3:    cl3 <= 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_idle_bank <= 1'b0;
         err_act_open  <= 1'b0;
         err_refresh   <= 1'b0;
         err_collide   <= 1'b0;
         refresh_cnt   <= 16'd0;
      end else begin
         err_idle_bank <= rw_cmd && !bank_open[ba];
         err_collide   <= rw_cmd && busy;
         err_act_open  <= is_act && bank_open[ba];
         err_refresh   <= is_ref && |bank_open;
         if (is_ref && !(|bank_open) && refresh_cnt != 16'hFFFF)
            refresh_cnt <= refresh_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dq_oe  <= 1'b0;
         dq_out <= '0;
      end else begin
         dq_oe  <= rd_fetch;
         dq_out <= rd_fetch ? mem[idx] : '0;
      end
   end

   // Memory is never cleared; a reset only suppresses the pending write word.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int i = 0; i < DM_W; i++)
            if (!dm[i]) mem[idx][8*i +: 8] <= dq_in[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_ddr_sdram_responder.sv
module tb_ddr_sdram_responder;

   localparam int DQ_W = 16, ADDR_W = 12, ROW_W = 4, COL_W = 5;
   localparam int K_LMR = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_REF = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [1:0]        ba = '0;
   logic [ADDR_W-1:0] addr = '0;
   logic [31:0]       dq_in = '0;
   logic [3:0]        dm = '0;
   logic [31:0]       dq_out;
   logic              dq_oe;
   logic              err_idle_bank, err_act_open, err_refresh, err_collide;
   logic [15:0]       refresh_cnt;

   ddr_sdram_responder #(.DQ_W(DQ_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
      .clk(clk), .reset(reset), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
      .ba(ba), .addr(addr), .dq_in(dq_in), .dm(dm), .dq_out(dq_out), .dq_oe(dq_oe),
      .err_idle_bank(err_idle_bank), .err_act_open(err_act_open),
      .err_refresh(err_refresh), .err_collide(err_collide), .refresh_cnt(refresh_cnt));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;

   typedef struct { int cyc; logic [31:0] data; logic [31:0] known; } rd_exp_t;
   typedef struct { int cyc; logic [3:0] bits; } err_exp_t;
   rd_exp_t  rdq[$];
   err_exp_t errq[$];

   // Reference model: protocol state in plain terms, memory as individual bytes
   bit   m_open [4];
   int   m_row [4];
   int   m_bl, m_cl, m_busy_until, m_ref;
   logic [7:0]  m_byte [int];
   logic [31:0] sched_dq [int];
   logic [3:0]  sched_dm [int];
   logic [31:0] plan_dq[$];
   logic [3:0]  plan_dm[$];

   task automatic tick();
      @(posedge clk);
      #1;
      cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
      if (sched_dq.exists(cyc)) begin
         dq_in = sched_dq[cyc];
         dm    = sched_dm[cyc];
      end else begin
         dq_in = $urandom;
         dm    = 4'($urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin m_open[i] = 0; m_row[i] = 0; end
      m_bl = 4; m_cl = 2; m_busy_until = -1; m_ref = 0;
   endtask

   task automatic do_reset(input int n);
      rd_exp_t  rk[$];
      err_exp_t ek[$];
      int t;
      t = cyc;
      reset = 1'b1;
      foreach (rdq[i])  if (rdq[i].cyc <= t)  rk.push_back(rdq[i]);
      foreach (errq[i]) if (errq[i].cyc <= t) ek.push_back(errq[i]);
      rdq = rk;
      errq = ek;
      model_reset();
      idle(n);
      reset = 1'b0;
   endtask

   task automatic issue(input int kind, input logic [1:0] b, input logic [ADDR_W-1:0] a);
      int t, nb, col, colb, bw;
      logic [3:0]  e;
      logic [31:0] d, kn;
      logic [3:0]  m;
      t = cyc;
      e = 4'b0000;
      cs_n = 1'b0; ba = b; addr = a;
      case (kind)
         K_LMR: {ras_n, cas_n, we_n} = 3'b000;
         K_ACT: {ras_n, cas_n, we_n} = 3'b011;
         K_RD:  {ras_n, cas_n, we_n} = 3'b101;
         K_WR:  {ras_n, cas_n, we_n} = 3'b100;
         K_PRE: {ras_n, cas_n, we_n} = 3'b010;
         default: {ras_n, cas_n, we_n} = 3'b001;
      endcase
      case (kind)
         K_LMR: if (b == 0) begin
            if (a[2:0] == 1) m_bl = 2;
            if (a[2:0] == 2) m_bl = 4;
            if (a[2:0] == 3) m_bl = 8;
            if (a[6:4] == 2 || a[6:4] == 3) m_cl = int'(a[6:4]);
         end
         K_ACT: if (m_open[b]) e[1] = 1'b1;
                else begin m_open[b] = 1; m_row[b] = int'(a[3:0]); end
         K_PRE: if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
                else m_open[b] = 0;
         K_REF: if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) e[2] = 1'b1;
                else if (m_ref < 65535) m_ref++;
         default: begin
            if (!m_open[b]) e[0] = 1'b1;
            if (t <= m_busy_until) e[3] = 1'b1;
            if (e == 4'b0000) begin
               nb  = m_bl / 2;
               col = int'(a[4:0]) & ~1;
               for (int k = 0; k < nb; k++) begin
                  colb = (col & ~(m_bl - 1)) | ((col + 2*k) & (m_bl - 1));
                  bw   = (int'(b) * 16 + m_row[b]) * 32 + colb;
                  if (kind == K_WR) begin
                     if (plan_dq.size() > 0) begin d = plan_dq.pop_front(); m = plan_dm.pop_front(); end
                     else begin d = $urandom; m = 4'($urandom); end
                     sched_dq[t+1+k] = d;
                     sched_dm[t+1+k] = m;
                     for (int i = 0; i < 4; i++) if (!m[i]) m_byte[bw*2+i] = d[8*i +: 8];
                  end else begin
                     d = '0; kn = '0;
                     for (int i = 0; i < 4; i++)
                        if (m_byte.exists(bw*2+i)) begin
                           d[8*i +: 8]  = m_byte[bw*2+i];
                           kn[8*i +: 8] = 8'hFF;
                        end
                     rdq.push_back('{t + m_cl + k, d, kn});
                  end
               end
               m_busy_until = (kind == K_WR) ? t + nb : t + m_cl + nb - 1;
            end
         end
      endcase
      if (e != 4'b0000) errq.push_back('{t + 1, e});
      tick();
   endtask

   task automatic check_ref(input int expv, input string nm);
      n_tests++;
      if (refresh_cnt != 16'(expv)) begin
         n_fail++;
         $display("FAIL %s: refresh_cnt got %0d expected %0d", nm, refresh_cnt, expv);
      end
   endtask

   // Monitor: pops expected words/error pulses as the DUT presents them
   always @(negedge clk) begin
      rd_exp_t  r;
      err_exp_t x;
      logic [3:0] act_e, exp_e;
      if (dq_oe) begin
         n_tests++;
         if (rdq.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: cycle %0d dq_out %h with nothing expected", cyc, dq_out);
         end else begin
            r = rdq.pop_front();
            if (r.cyc != cyc || ((dq_out ^ r.data) & r.known) != 0) begin
               n_fail++;
               $display("FAIL rd_data: cycle %0d dq_out %h, expected cycle %0d data %h (known %h)",
                        cyc, dq_out, r.cyc, r.data, r.known);
            end
         end
      end else begin
         while (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
            r = rdq.pop_front();
            n_tests++; n_fail++;
            $display("FAIL rd_missing: cycle %0d dq_oe 0, expected data %h", cyc, r.data);
         end
         n_tests++;
         if (dq_out != 32'h0) begin
            n_fail++;
            $display("FAIL dq_idle: cycle %0d dq_out %h expected 0", cyc, dq_out);
         end
      end
      while (errq.size() > 0 && errq[0].cyc < cyc) begin
         x = errq.pop_front();
         n_tests++; n_fail++;
         $display("FAIL err_stale: expected %b at cycle %0d never matched", x.bits, x.cyc);
      end
      act_e = {err_collide, err_refresh, err_act_open, err_idle_bank};
      exp_e = 4'b0000;
      if (errq.size() > 0 && errq[0].cyc == cyc) begin
         x = errq.pop_front();
         exp_e = x.bits;
      end
      if (act_e != 4'b0000 || exp_e != 4'b0000) begin
         n_tests++;
         if (act_e != exp_e) begin
            n_fail++;
            $display("FAIL err_bits: cycle %0d {collide,refresh,act_open,idle_bank} got %b expected %b",
                     cyc, act_e, exp_e);
         end
      end
   end

   initial begin
      int r;
      model_reset();
      do_reset(3);
      check_ref(0, "reset_refresh_cnt");

      // Basic write/read, BL4 CL2
      issue(K_ACT, 2'd1, 12'd3);
      plan_dq = '{32'hBBBBAAAA, 32'hDDDDCCCC}; plan_dm = '{4'h0, 4'h0};
      issue(K_WR, 2'd1, 12'd4);
      idle(3);
      issue(K_RD, 2'd1, 12'd4);
      idle(4);

      // BL8 CL3 with wrap
      issue(K_LMR, 2'd0, 12'h033);
      for (int k = 0; k < 4; k++) begin
         plan_dq.push_back({16'(2*k+1), 16'(2*k)});
         plan_dm.push_back(4'h0);
      end
      issue(K_WR, 2'd1, 12'd0);
      idle(5);
      issue(K_RD, 2'd1, 12'd6);
      idle(8);

      // Byte masks, back to BL4 CL2
      issue(K_LMR, 2'd0, 12'h022);
      plan_dq = '{32'hFFFFFFFF, 32'hFFFFFFFF}; plan_dm = '{4'h0, 4'h0};
      issue(K_WR, 2'd1, 12'd8);
      idle(3);
      plan_dq = '{32'h11223344, 32'h11223344}; plan_dm = '{4'b0101, 4'b0101};
      issue(K_WR, 2'd1, 12'd8);
      idle(3);
      issue(K_RD, 2'd1, 12'd8);
      idle(4);

      // Protocol errors
      issue(K_RD, 2'd2, 12'd0);
      idle(2);
      issue(K_ACT, 2'd0, 12'd5);
      issue(K_ACT, 2'd0, 12'd6);
      issue(K_REF, 2'd0, 12'd0);
      idle(1);
      check_ref(0, "refresh_blocked");

      // Collision on the last read word, then back-to-back accept
      issue(K_WR, 2'd0, 12'd16);
      idle(3);
      issue(K_RD, 2'd0, 12'd16);
      idle(2);
      issue(K_WR, 2'd0, 12'd16);
      issue(K_WR, 2'd0, 12'd20);
      issue(K_RD, 2'd0, 12'd20);
      issue(K_RD, 2'd0, 12'd16);
      idle(2);
      issue(K_PRE, 2'd0, 12'h400);
      issue(K_REF, 2'd0, 12'd0);
      issue(K_REF, 2'd0, 12'd0);
      issue(K_REF, 2'd0, 12'd0);
      idle(1);
      check_ref(3, "refresh_three");

      // Reset during a BL8 read's second data cycle
      issue(K_LMR, 2'd0, 12'h033);
      issue(K_ACT, 2'd3, 12'd2);
      issue(K_WR, 2'd3, 12'd0);
      idle(5);
      issue(K_RD, 2'd3, 12'd0);
      idle(3);
      do_reset(2);
      check_ref(0, "reset_mid_burst_cnt");
      issue(K_RD, 2'd3, 12'd0);
      issue(K_ACT, 2'd3, 12'd2);
      issue(K_RD, 2'd3, 12'd0);
      idle(4);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 22)      issue(K_ACT, 2'($urandom), 12'($urandom));
         else if (r < 42) issue(K_WR, 2'($urandom), 12'($urandom));
         else if (r < 64) issue(K_RD, 2'($urandom), 12'($urandom));
         else if (r < 74) issue(K_PRE, 2'($urandom), ($urandom_range(0, 3) == 0) ? 12'h400 : 12'h000);
         else if (r < 79) issue(K_REF, 2'($urandom), 12'($urandom));
         else if (r < 85) issue(K_LMR, 2'($urandom_range(0, 1) * $urandom_range(0, 3)), 12'($urandom));
         else             tick();
         if (i % 50 == 49) check_ref(m_ref, "refresh_random");
      end
      idle(20);

      n_tests++;
      if (rdq.size() != 0 || errq.size() != 0) begin
         n_fail++;
         $display("FAIL queues_drained: %0d reads and %0d errors still expected", rdq.size(), errq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
